// File: rtl/regfile_pkg.sv
// Shared types and default widths for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bus of the register file: read ports, write port, reserve and bulk clear.
interface regfile_sb_if
  import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);

   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              clr;
   logic              clr_busy;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr,
      input  rd_data1, rd_data2, rd_busy1, rd_busy2, clr_busy
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr,
      output rd_data1, rd_data2, rd_busy1, rd_busy2, clr_busy
   );

endinterface

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: sweeps every entry once, one per cycle, after a clr pulse.
module regfile_clr_seq
  import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   output logic              clr_busy,
   output logic              clr_en_c,
   output logic [ADDR_W-1:0] clr_addr_c
);

   localparam int unsigned       DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_busy_q, clr_busy_d;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         clr_busy_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_busy_q <= clr_busy_d;
      end
   end

   // Next state; the sweep ends on an explicit compare with the last entry
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      clr_busy_d = (state_d == ST_CLEAR);
      clr_en_c   = (state_q == ST_CLEAR);
      clr_addr_c = cnt_q;
   end

   assign clr_busy = clr_busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with busy scoreboard, write-to-read bypass and bulk clear.
module regfile_sb
  import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);

   localparam int unsigned       DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;

   logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
   logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
   logic              rd_busy1_q, rd_busy1_d;
   logic              rd_busy2_q, rd_busy2_d;

   logic              clr_busy;
   logic              clr_en_c;
   logic [ADDR_W-1:0] clr_addr_c;
   logic              wr_ok_c;
   logic              rsv_ok_c;

   regfile_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk        (clk),
      .rst        (rst),
      .clr        (bus.clr),
      .clr_busy   (clr_busy),
      .clr_en_c   (clr_en_c),
      .clr_addr_c (clr_addr_c)
   );

   // Writes and reserves are only accepted outside the sweep, and never to a hardwired zero entry
   always_comb begin
      wr_ok_c  = bus.wr_en  && !clr_en_c && !((ZERO_REG != 0) && (bus.wr_addr  == ADDR_ZERO));
      rsv_ok_c = bus.rsv_en && !clr_en_c && !((ZERO_REG != 0) && (bus.rsv_addr == ADDR_ZERO));
   end

   // Storage and scoreboard update; reserve is applied after write so a newer producer wins
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      if (clr_en_c) begin
         mem_d[clr_addr_c]  = '0;
         busy_d[clr_addr_c] = 1'b0;
      end else begin
         if (wr_ok_c) begin
            mem_d[bus.wr_addr]  = bus.wr_data;
            busy_d[bus.wr_addr] = 1'b0;
         end
         if (rsv_ok_c) begin
            busy_d[bus.rsv_addr] = 1'b1;
         end
      end
   end

   // Read ports: pre-edge storage, or forwarded write data with its post-edge busy bit
   always_comb begin
      rd_data1_d = mem_q[bus.rd_addr1];
      rd_busy1_d = busy_q[bus.rd_addr1];
      rd_data2_d = mem_q[bus.rd_addr2];
      rd_busy2_d = busy_q[bus.rd_addr2];
      if ((ZERO_REG != 0) && (bus.rd_addr1 == ADDR_ZERO)) begin
         rd_data1_d = '0;
         rd_busy1_d = 1'b0;
      end
      if ((ZERO_REG != 0) && (bus.rd_addr2 == ADDR_ZERO)) begin
         rd_data2_d = '0;
         rd_busy2_d = 1'b0;
      end
      if ((BYPASS != 0) && wr_ok_c && (bus.wr_addr == bus.rd_addr1)) begin
         rd_data1_d = bus.wr_data;
         rd_busy1_d = busy_d[bus.rd_addr1];
      end
      if ((BYPASS != 0) && wr_ok_c && (bus.wr_addr == bus.rd_addr2)) begin
         rd_data2_d = bus.wr_data;
         rd_busy2_d = busy_d[bus.rd_addr2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q     <= '0;
         rd_data1_q <= '0;
         rd_data2_q <= '0;
         rd_busy1_q <= 1'b0;
         rd_busy2_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         busy_q     <= busy_d;
         rd_data1_q <= rd_data1_d;
         rd_data2_q <= rd_data2_d;
         rd_busy1_q <= rd_busy1_d;
         rd_busy2_q <= rd_busy2_d;
      end
   end

   assign bus.rd_data1 = rd_data1_q;
   assign bus.rd_data2 = rd_data2_q;
   assign bus.rd_busy1 = rd_busy1_q;
   assign bus.rd_busy2 = rd_busy2_q;
   assign bus.clr_busy = clr_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: instance A (ZERO_REG=1, BYPASS=1) and instance B (ZERO_REG=0, BYPASS=0) on shared stimulus.
module tb_regfile_sb;

   logic        clk;
   logic        rst;
   logic [3:0]  rd_a1, rd_a2, wr_addr, rsv_addr;
   logic [15:0] wr_data;
   logic        wr_en, rsv_en, clr;

   int checks = 0;
   int errors = 0;

   regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) ifa ();
   regfile_sb_if #(.DATA_W(16), .ADDR_W(4)) ifb ();

   assign ifa.rd_addr1 = rd_a1;   assign ifb.rd_addr1 = rd_a1;
   assign ifa.rd_addr2 = rd_a2;   assign ifb.rd_addr2 = rd_a2;
   assign ifa.wr_en    = wr_en;   assign ifb.wr_en    = wr_en;
   assign ifa.wr_addr  = wr_addr; assign ifb.wr_addr  = wr_addr;
   assign ifa.wr_data  = wr_data; assign ifb.wr_data  = wr_data;
   assign ifa.rsv_en   = rsv_en;  assign ifb.rsv_en   = rsv_en;
   assign ifa.rsv_addr = rsv_addr;assign ifb.rsv_addr = rsv_addr;
   assign ifa.clr      = clr;     assign ifb.clr      = clr;

   regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk (clk), .rst (rst), .bus (ifa));
   regfile_sb #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk (clk), .rst (rst), .bus (ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: index 0 = instance A, index 1 = instance B
   logic [15:0] m_mem  [2][16];
   logic [15:0] m_busy [2];
   logic [15:0] e_d1 [2], e_d2 [2];
   logic        e_b1 [2], e_b2 [2], e_cb [2];
   bit          m_sweep [2];
   int          m_cnt [2];
   bit          zr, bp, wacc, racc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) m_mem[i][j] = 16'h0;
            m_busy[i] = 16'h0;
            e_d1[i] = 16'h0; e_d2[i] = 16'h0;
            e_b1[i] = 1'b0;  e_b2[i] = 1'b0; e_cb[i] = 1'b0;
            m_sweep[i] = 1'b0; m_cnt[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            zr = (i == 0);
            bp = (i == 0);
            e_d1[i] = (zr && rd_a1 == 0) ? 16'h0 : m_mem[i][rd_a1];
            e_b1[i] = (zr && rd_a1 == 0) ? 1'b0  : m_busy[i][rd_a1];
            e_d2[i] = (zr && rd_a2 == 0) ? 16'h0 : m_mem[i][rd_a2];
            e_b2[i] = (zr && rd_a2 == 0) ? 1'b0  : m_busy[i][rd_a2];
            if (!m_sweep[i]) begin
               wacc = wr_en  && !(zr && wr_addr == 0);
               racc = rsv_en && !(zr && rsv_addr == 0);
               if (wacc) begin
                  m_mem[i][wr_addr]  = wr_data;
                  m_busy[i][wr_addr] = 1'b0;
               end
               if (racc) m_busy[i][rsv_addr] = 1'b1;
               if (bp && wacc && wr_addr == rd_a1) begin
                  e_d1[i] = wr_data; e_b1[i] = m_busy[i][rd_a1];
               end
               if (bp && wacc && wr_addr == rd_a2) begin
                  e_d2[i] = wr_data; e_b2[i] = m_busy[i][rd_a2];
               end
               if (clr) begin
                  m_sweep[i] = 1'b1; m_cnt[i] = 0;
               end
            end else begin
               m_mem[i][m_cnt[i]]  = 16'h0;
               m_busy[i][m_cnt[i]] = 1'b0;
               if (m_cnt[i] == 15) m_sweep[i] = 1'b0;
               m_cnt[i] = (m_cnt[i] + 1) % 16;
            end
            e_cb[i] = m_sweep[i];
         end
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (!rst) begin
         chk("a_rd_data1", ifa.rd_data1, e_d1[0]);
         chk("a_rd_data2", ifa.rd_data2, e_d2[0]);
         chk("a_rd_busy1", ifa.rd_busy1, e_b1[0]);
         chk("a_rd_busy2", ifa.rd_busy2, e_b2[0]);
         chk("a_clr_busy", ifa.clr_busy, e_cb[0]);
         chk("b_rd_data1", ifb.rd_data1, e_d1[1]);
         chk("b_rd_data2", ifb.rd_data2, e_d2[1]);
         chk("b_rd_busy1", ifb.rd_busy1, e_b1[1]);
         chk("b_rd_busy2", ifb.rd_busy2, e_b2[1]);
         chk("b_clr_busy", ifb.clr_busy, e_cb[1]);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic fill();
      for (int a = 1; a < 16; a++) begin
         wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'(a * 16'h1111);
         cyc();
      end
      wr_en = 1'b0;
   endtask

   // Pulse clr and count how many sampled cycles clr_busy stays high; inject a write/reserve mid-sweep
   task automatic sweep(output int na, output int nb);
      rd_a1 = 4'd2; rd_a2 = 4'd8;
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      na = 0; nb = 0;
      for (int k = 0; k < 40; k++) begin
         if (ifa.clr_busy) na++;
         if (ifb.clr_busy) nb++;
         if (k == 5) begin
            wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hDEAD;
            rsv_en = 1'b1; rsv_addr = 4'd8; clr = 1'b1;
         end else begin
            wr_en = 1'b0; rsv_en = 1'b0; clr = 1'b0;
         end
         cyc();
      end
   endtask

   task automatic readback_zero(input string tag);
      for (int a = 0; a < 16; a++) begin
         rd_a1 = 4'(a); rd_a2 = 4'(15 - a);
         cyc();
         chk({tag, "_a_d1"}, ifa.rd_data1, 32'h0);
         chk({tag, "_b_d2"}, ifb.rd_data2, 32'h0);
         chk({tag, "_a_b1"}, ifa.rd_busy1, 32'h0);
      end
   endtask

   int na, nb;

   initial begin
      rst = 1'b1; rd_a1 = '0; rd_a2 = '0; wr_addr = '0; rsv_addr = '0;
      wr_data = '0; wr_en = 1'b0; rsv_en = 1'b0; clr = 1'b0;
      cyc(); cyc();
      rst = 1'b0;

      // Bypass on A, stale read on B
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555; rd_a1 = 4'd5;
      cyc();
      wr_en = 1'b0;
      chk("lit_a_byp5", ifa.rd_data1, 32'h5555);
      chk("lit_b_old5", ifb.rd_data1, 32'h0);
      cyc();
      chk("lit_b_new5", ifb.rd_data1, 32'h5555);

      // Reset asserted mid-cycle clears outputs at once
      #2 rst = 1'b1;
      #1;
      chk("lit_rst_a_d1", ifa.rd_data1, 32'h0);
      chk("lit_rst_b_d1", ifb.rd_data1, 32'h0);
      chk("lit_rst_a_b1", ifa.rd_busy1, 32'h0);
      chk("lit_rst_a_cb", ifa.clr_busy, 32'h0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("lit_rd5_after_rst", ifa.rd_data1, 32'h0);

      // Write then read back next cycle
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; rd_a2 = 4'd3;
      cyc();
      wr_en = 1'b0;
      cyc();
      chk("lit_a_r3", ifa.rd_data2, 32'hBEEF);
      chk("lit_b_r3", ifb.rd_data2, 32'hBEEF);

      // Entry 0: hardwired on A, ordinary on B
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd_a2 = 4'd0;
      cyc();
      wr_en = 1'b0;
      cyc();
      chk("lit_a_r0", ifa.rd_data2, 32'h0);
      chk("lit_b_r0", ifb.rd_data2, 32'h1234);

      // Bypass on r7
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hA5A5; rd_a1 = 4'd7;
      cyc();
      wr_en = 1'b0;
      chk("lit_a_byp7", ifa.rd_data1, 32'hA5A5);
      chk("lit_b_old7", ifb.rd_data1, 32'h0);
      cyc();
      chk("lit_b_new7", ifb.rd_data1, 32'hA5A5);

      // Scoreboard on r4
      rsv_en = 1'b1; rsv_addr = 4'd4; rd_a1 = 4'd4;
      cyc();
      rsv_en = 1'b0;
      cyc();
      chk("lit_a_rsv4", ifa.rd_busy1, 32'h1);
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444;
      cyc();
      wr_en = 1'b0;
      chk("lit_a_wr4_byp_busy", ifa.rd_busy1, 32'h0);
      chk("lit_b_wr4_old_busy", ifb.rd_busy1, 32'h1);
      cyc();
      chk("lit_b_wr4_busy", ifb.rd_busy1, 32'h0);
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4321;
      rsv_en = 1'b1; rsv_addr = 4'd4;
      cyc();
      wr_en = 1'b0; rsv_en = 1'b0;
      chk("lit_a_wrrsv4_busy", ifa.rd_busy1, 32'h1);
      chk("lit_a_wrrsv4_data", ifa.rd_data1, 32'h4321);
      cyc();
      chk("lit_b_wrrsv4_busy", ifb.rd_busy1, 32'h1);
      chk("lit_b_wrrsv4_data", ifb.rd_data1, 32'h4321);
      rsv_en = 1'b1; rsv_addr = 4'd0; rd_a2 = 4'd0;
      cyc();
      rsv_en = 1'b0;
      cyc();
      chk("lit_a_rsv0", ifa.rd_busy2, 32'h0);
      chk("lit_b_rsv0", ifb.rd_busy2, 32'h1);

      // Write and reserve to different entries in the same cycle
      wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h0606;
      rsv_en = 1'b1; rsv_addr = 4'd9; rd_a1 = 4'd6; rd_a2 = 4'd9;
      cyc();
      wr_en = 1'b0; rsv_en = 1'b0;
      cyc();
      chk("lit_a_r6", ifa.rd_data1, 32'h0606);
      chk("lit_a_busy9", ifa.rd_busy2, 32'h1);

      // Full sweep
      fill();
      sweep(na, nb);
      chk("lit_a_sweep_len", 32'(na), 32'd16);
      chk("lit_b_sweep_len", 32'(nb), 32'd16);
      readback_zero("clr");

      // Reset in the sixth sweep cycle, then a fresh sweep
      fill();
      rsv_en = 1'b1; rsv_addr = 4'd10;
      cyc();
      rsv_en = 1'b0;
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      for (int k = 0; k < 5; k++) cyc();
      chk("lit_a_mid_sweep", ifa.clr_busy, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("lit_a_rst_sweep_cb", ifa.clr_busy, 32'h0);
      chk("lit_b_rst_sweep_cb", ifb.clr_busy, 32'h0);
      cyc();
      rst = 1'b0;
      readback_zero("rst");
      fill();
      sweep(na, nb);
      chk("lit_a_sweep2_len", 32'(na), 32'd16);
      chk("lit_b_sweep2_len", 32'(nb), 32'd16);
      readback_zero("clr2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
